accu_dump: RTL and testbench
============================

# accu_dump

Parametrised multi-channel integrate-and-dump accumulator, the successor to the single-channel plain and modulo accumulators. It sums CH independent input lanes per accepted sample, either as plain binary sums or modulo M. Every LEN accepted samples it emits a one-cycle dump of all lane totals and restarts the sums from zero. It sits between sample sources (counters, ADC front ends, test pattern generators) and downstream averaging or statistics logic.

## Interface
- `W`, 8: input lane width in bits.
- `AW`, 16: accumulator lane width in bits; `AW >= W`.
- `CH`, 4: number of independent lanes, 1 to 16.
- `M`, 0: modulus. 0 selects plain binary mode. A value greater than 0 selects modulo mode, with `M <= 2**AW - 1`.
- `LEN`, 16: accepted samples per dump, 0 to 65535. 0 disables dumping.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clr`  in  1: synchronous clear of sums, sample counter and overflow flags.
- `en`  in  1: sample accept strobe; `d` is consumed on every cycle where `en=1` and `clr=0`.
- `d`  in  CH*W: input lanes; lane i is `d[i*W +: W]`, zero-extended to AW bits.
- `acc`  out  CH*AW: running sums, registered.
- `dump_valid`  out  1: one-cycle pulse marking a completed window.
- `dump_data`  out  CH*AW: window totals; held until the next dump, clr or rst.
- `ovf`  out  CH: per-lane sticky overflow flags; always 0 in modulo mode.
- `cnt`  out  16: number of accepted samples in the current window.

## Operation
- Priority: `rst` > `clr` > `en`.
- Reset and clear: `acc=0`, `cnt=0`, `ovf=0`, `dump_valid=0`, `dump_data=0`. A `clr` asserted together with `en` discards that sample.
- Plain mode (`M=0`): `s = acc_i + d_i`, computed at AW+1 bits.
  - A carry out (bit AW set) sets `ovf[i]`, and the flag stays set until clr or rst.
  - The result wraps to AW bits; saturating behaviour is covered under Configuration.
- Modulo mode (`M>0`): `acc_i` takes `s-M` if `s >= M`, otherwise `s`.
  - Precondition: `d_i < M`. The bench asserts it; the RTL does not check it.
  - With the precondition met, `acc_i < M` holds invariantly and `ovf` stays 0.
- Sample counter: `cnt` increments on each accepted sample.
- Window close: on the accepted sample where `cnt == LEN-1` (LEN > 0):
  - `dump_data` loads the totals including that sample.
  - `dump_valid` is 1 in the following cycle.
  - `acc` and `cnt` load 0.
  - `ovf` is not cleared by a dump.
- `LEN=0`: `cnt` saturates at 65535 and never dumps. `acc` accumulates indefinitely.
- `LEN=1`: every accepted sample dumps, so `dump_data = d` (modulo M in modulo mode) and `acc` stays 0.
- `en=0` cycles hold all state. `dump_valid` is 0 on every cycle except the one following a window close.
- There is no backpressure; the consumer must take `dump_data` within LEN accepted samples.

## Timing
- Latency is 1 cycle: a sample accepted at edge k appears in `acc` after edge k.
- `dump_valid` and the new `dump_data` become visible after the same edge that zeroes `acc`.
- Reset is synchronous. Asserting `rst` mid-window drops the partial window with no dump pulse.
- A reset or clear coinciding with a window-closing sample suppresses that dump.
- Back-to-back dumps are possible with `LEN=1`, giving `dump_valid=1` on consecutive cycles.
- The only state machine is the window counter: IDLE/ACCUM is implicit in `cnt`, and there is no separate FSM register.

## Configuration
- `ACCU_SAT_EN` defined: in plain mode, a lane whose sum carries out clamps to `2**AW-1` and sets `ovf[i]`. The lane stays clamped until clr, rst or a dump.
- `ACCU_SAT_EN` undefined: plain mode wraps modulo `2**AW` and still sets `ovf[i]`.
- Modulo mode is unaffected either way.

## Test plan
- Reset, then ramp: `W=8, AW=16, CH=2, M=0, LEN=4`.
  - Stimulus: `en=1`, lane0 d=1,2,3,4, lane1 d=10,10,10,10.
  - Required: acc0 = 1, 3, 6, then 0; `dump_valid` pulses once with dump_data lane0=10, lane1=40; `cnt` returns to 0.
- Modulo check: `M=50, LEN=0`, d ramps from 0 by 1 per cycle, with each sample reduced below 50.
  - Required: `acc` equals the running sum mod 50 on every cycle; `ovf=0`.
- Overflow: `AW=8, W=8, M=0, LEN=0`, d=200 twice.
  - Required without `ACCU_SAT_EN`: acc=144, ovf=1.
  - Required with `ACCU_SAT_EN`: acc=255, ovf=1.
- Clear priority: `clr=1` together with `en=1`, d=7, mid-window at cnt=2.
  - Required next cycle: acc=0, cnt=0, ovf=0, no dump.
- Gaps and reset: `LEN=3`, `en` pattern 1,0,1,0,1.
  - Required: exactly one `dump_valid`, on the cycle after the third accepted sample.
  - Repeat with `rst` asserted at cnt=2: no dump, all outputs 0.
- `LEN=1`, d=5 for 3 cycles.
  - Required: `dump_valid` high 3 consecutive cycles, dump_data=5, acc=0 throughout.

Source files
------------

// File: rtl/accu_dump.sv
// accu_dump: multi-lane integrate-and-dump accumulator, plain or modulo M.
// Optional ACCU_SAT_EN: plain-mode lanes clamp at all-ones on carry out.
module accu_dump #(
   parameter int W   = 8,
   parameter int AW  = 16,
   parameter int CH  = 4,
   parameter int M   = 0,
   parameter int LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CH*W-1:0]  d,
   output logic [CH*AW-1:0] acc,
   output logic             dump_valid,
   output logic [CH*AW-1:0] dump_data,
   output logic [CH-1:0]    ovf,
   output logic [15:0]      cnt
);

   localparam logic [AW:0] MOD  = (AW+1)'(M);
   localparam logic [15:0] LAST =
      (LEN > 0) ? 16'(LEN - 1) : 16'hFFFF;
   localparam bit DUMP_EN = (LEN > 0);
   localparam bit MOD_EN  = (M > 0);

   logic [CH*AW-1:0] acc_nx;
   logic [CH-1:0]    carry;
   logic [AW:0]      s;
   logic             close;

   // per-lane next sum: wrap/clamp in plain mode, reduce in modulo mode
   always_comb begin
      acc_nx = '0;
      carry  = '0;
      s      = '0;
      for (int i = 0; i < CH; i++) begin
         s = {1'b0, acc[i*AW +: AW]}
           + {{(AW+1-W){1'b0}}, d[i*W +: W]};
         if (MOD_EN) begin
            if (s >= MOD)
               s = s - MOD;
            acc_nx[i*AW +: AW] = s[AW-1:0];
         end else begin
            carry[i] = s[AW];
`ifdef ACCU_SAT_EN
            acc_nx[i*AW +: AW] =
               s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
            acc_nx[i*AW +: AW] = s[AW-1:0];
`endif
         end
      end
   end

   // an accepted sample at the last window slot closes the window
   always_comb begin
      close = en && DUMP_EN && (cnt == LAST);
   end

   // state update: rst/clr wipe everything, en accumulates or dumps
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc        <= '0;
         cnt        <= '0;
         ovf        <= '0;
         dump_valid <= 1'b0;
         dump_data  <= '0;
      end else begin
         dump_valid <= 1'b0;
         if (en) begin
            ovf <= ovf | carry;
            if (close) begin
               acc        <= '0;
               cnt        <= '0;
               dump_data  <= acc_nx;
               dump_valid <= 1'b1;
            end else begin
               acc <= acc_nx;
               if (cnt != 16'hFFFF)
                  cnt <= cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_accu_dump.sv
// tb_accu_dump: vectors, corner sequences and a random model check
// across several parameterisations of accu_dump sharing one stimulus.
module tb_accu_dump;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        en  = 1'b0;
   logic [15:0] d   = '0;

   logic [31:0] acc_a, dd_a, acc_m, dd_m, acc_g, dd_g, acc_1, dd_1;
   logic [15:0] acc_o, dd_o;
   logic        dv_a, dv_m, dv_o, dv_g, dv_1;
   logic [1:0]  ovf_a, ovf_m, ovf_o, ovf_g, ovf_1;
   logic [15:0] cnt_a, cnt_m, cnt_o, cnt_g, cnt_1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   accu_dump #(.W(8), .AW(16), .CH(2), .M(0), .LEN(4)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
      .acc(acc_a), .dump_valid(dv_a), .dump_data(dd_a),
      .ovf(ovf_a), .cnt(cnt_a));

   accu_dump #(.W(8), .AW(16), .CH(2), .M(50), .LEN(0)) u_m (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
      .acc(acc_m), .dump_valid(dv_m), .dump_data(dd_m),
      .ovf(ovf_m), .cnt(cnt_m));

   accu_dump #(.W(8), .AW(8), .CH(2), .M(0), .LEN(0)) u_o (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
      .acc(acc_o), .dump_valid(dv_o), .dump_data(dd_o),
      .ovf(ovf_o), .cnt(cnt_o));

   accu_dump #(.W(8), .AW(16), .CH(2), .M(0), .LEN(3)) u_g (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
      .acc(acc_g), .dump_valid(dv_g), .dump_data(dd_g),
      .ovf(ovf_g), .cnt(cnt_g));

   accu_dump #(.W(8), .AW(16), .CH(2), .M(0), .LEN(1)) u_1 (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
      .acc(acc_1), .dump_valid(dv_1), .dump_data(dd_1),
      .ovf(ovf_1), .cnt(cnt_1));

   typedef struct {
      logic en;
      logic clr;
      int   d0;
      int   d1;
      int   a0;
      int   a1;
      logic dv;
      int   cn;
      int   dd0;
      int   dd1;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic c,
                        input int d0, input int d1);
      en = e;
      clr = c;
      d = {8'(d1), 8'(d0)};
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // random-run reference state
   int  ms0, ms1, mn, mdd0, mdd1;
   logic mdv;
   logic [1:0] movf;
   int  qs0, qs1, qn;

   initial begin
      tv[0] = '{1, 0, 1, 10,  1, 10, 0, 1,  0,  0};
      tv[1] = '{1, 0, 2, 10,  3, 20, 0, 2,  0,  0};
      tv[2] = '{1, 0, 3, 10,  6, 30, 0, 3,  0,  0};
      tv[3] = '{1, 0, 4, 10,  0,  0, 1, 0, 10, 40};
      tv[4] = '{0, 0, 9,  9,  0,  0, 0, 0, 10, 40};
      tv[5] = '{1, 0, 1,  1,  1,  1, 0, 1, 10, 40};
      tv[6] = '{1, 0, 1,  1,  2,  2, 0, 2, 10, 40};
      tv[7] = '{1, 1, 7,  7,  0,  0, 0, 0,  0,  0};
      tv[8] = '{1, 0, 7,  7,  7,  7, 0, 1,  0,  0};

      // reset state
      drive(0, 0, 0, 0);
      step();
      step();
      chk("rst_acc", acc_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_dv",  dv_a, 0);
      chk("rst_dd",  dd_a, 0);
      chk("rst_ovf", ovf_a, 0);
      rst = 1'b0;

      // ramp, dump, hold, clear priority
      for (int i = 0; i < 9; i++) begin
         drive(tv[i].en, tv[i].clr, tv[i].d0, tv[i].d1);
         step();
         chk($sformatf("vec%0d_acc", i), acc_a,
             {16'(tv[i].a1), 16'(tv[i].a0)});
         chk($sformatf("vec%0d_dv", i), dv_a, tv[i].dv);
         chk($sformatf("vec%0d_cnt", i), cnt_a, tv[i].cn);
         chk($sformatf("vec%0d_dd", i), dd_a,
             {16'(tv[i].dd1), 16'(tv[i].dd0)});
         chk($sformatf("vec%0d_ovf", i), ovf_a, 0);
      end

      // modulo 50, endless window
      do_reset();
      qs0 = 0;
      qs1 = 0;
      for (int k = 0; k < 100; k++) begin
         drive(1, 0, k % 50, (3 * k + 7) % 50);
         assert (d[7:0] < 50 && d[15:8] < 50);
         step();
         qs0 = (qs0 + k % 50) % 50;
         qs1 = (qs1 + (3 * k + 7) % 50) % 50;
         chk("mod_acc", acc_m, {16'(qs1), 16'(qs0)});
         chk("mod_ovf", ovf_m, 0);
      end
      chk("mod_cnt", cnt_m, 100);
      chk("mod_dv", dv_m, 0);

      // overflow on an 8-bit accumulator
      do_reset();
      drive(1, 0, 200, 100);
      step();
      step();
`ifdef ACCU_SAT_EN
      chk("ovf_acc", acc_o, {8'd200, 8'd255});
`else
      chk("ovf_acc", acc_o, {8'd200, 8'd144});
`endif
      chk("ovf_flag", ovf_o, 2'b01);

      // gaps in en with LEN=3
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(i < 5 && i % 2 == 0, 0, 1, 2);
         step();
         chk($sformatf("gap%0d_dv", i), dv_g, i == 4);
         if (i == 4) begin
            chk("gap_dd", dd_g, {16'd6, 16'd3});
            chk("gap_acc", acc_g, 0);
            chk("gap_cnt", cnt_g, 0);
         end
      end

      // reset on the would-be closing sample
      drive(1, 0, 1, 2);
      step();
      step();
      chk("rstw_cnt2", cnt_g, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_dv", dv_g, 0);
      chk("rstw_acc", acc_g, 0);
      chk("rstw_cnt", cnt_g, 0);
      chk("rstw_dd", dd_g, 0);
      chk("rstw_ovf", ovf_g, 0);
      drive(0, 0, 0, 0);
      step();
      chk("rstw_dv2", dv_g, 0);

      // LEN=1 back-to-back dumps
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 5, 5);
         step();
         chk($sformatf("len1_dv%0d", i), dv_1, 1);
         chk($sformatf("len1_dd%0d", i), dd_1,
             {16'd5, 16'd5});
         chk($sformatf("len1_acc%0d", i), acc_1, 0);
      end
      drive(0, 0, 0, 0);
      step();
      chk("len1_dv_end", dv_1, 0);
      chk("len1_dd_end", dd_1, {16'd5, 16'd5});

      // random traffic against the reference model
      do_reset();
      ms0 = 0; ms1 = 0; mn = 0; mdd0 = 0; mdd1 = 0;
      mdv = 0; movf = 0;
      qs0 = 0; qs1 = 0; qn = 0;
      for (int k = 0; k < 300; k++) begin
         automatic logic e = ($urandom_range(0, 9) < 7);
         automatic logic c = ($urandom_range(0, 19) == 0);
         automatic int r0 = $urandom_range(0, 49);
         automatic int r1 = $urandom_range(0, 49);
         drive(e, c, r0, r1);
         step();
         mdv = 0;
         if (c) begin
            ms0 = 0; ms1 = 0; mn = 0;
            mdd0 = 0; mdd1 = 0; movf = 0;
            qs0 = 0; qs1 = 0; qn = 0;
         end else if (e) begin
            ms0 += r0;
            ms1 += r1;
            if (ms0 > 65535) begin movf[0] = 1; ms0 -= 65536; end
            if (ms1 > 65535) begin movf[1] = 1; ms1 -= 65536; end
            mn++;
            if (mn == 4) begin
               mdd0 = ms0; mdd1 = ms1;
               ms0 = 0; ms1 = 0; mn = 0;
               mdv = 1;
            end
            qs0 = (qs0 + r0) % 50;
            qs1 = (qs1 + r1) % 50;
            if (qn < 65535) qn++;
         end
         chk("rnd_acc", acc_a, {16'(ms1), 16'(ms0)});
         chk("rnd_cnt", cnt_a, mn);
         chk("rnd_dv",  dv_a, mdv);
         chk("rnd_dd",  dd_a, {16'(mdd1), 16'(mdd0)});
         chk("rnd_ovf", ovf_a, movf);
         chk("rnd_macc", acc_m, {16'(qs1), 16'(qs0)});
         chk("rnd_mcnt", cnt_m, qn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
